// File: rtl/bus_dma.sv
// bus_dma: bus initiator that copies a byte range (src -> dst) or fills a
// destination range with a constant byte. It drives the shared memory bus
// while busy, so the CPU is held off the bus. Slow targets stretch an
// access by raising bus_halt, which freezes the access in place.
//
// Ports:
//   clk           system clock, rising-edge
//   reset         asynchronous reset, active-low
//   start         one-cycle request, sampled only when idle
//   mode          0 = copy src->dst, 1 = fill dst with fill_value
//   src_address   first source byte (captured on start)
//   dst_address   first destination byte (captured on start)
//   length        byte count (captured on start), 0 = no transfer
//   fill_value    fill byte (captured on start)
//   busy          transfer in progress
//   done          one-cycle completion pulse
//   address       bus address
//   data_out      bus write data
//   data_in       bus read data
//   bus_enable    bus access active
//   write_enable  bus write strobe
//   bus_halt      target not ready; hold the current access
module bus_dma #(
    parameter int LENGTH_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    mode,
    input  logic [23:0]             src_address,
    input  logic [23:0]             dst_address,
    input  logic [LENGTH_WIDTH-1:0] length,
    input  logic [7:0]              fill_value,
    output logic                    busy,
    output logic                    done,
    output logic [23:0]             address,
    output logic [7:0]              data_out,
    input  logic [7:0]              data_in,
    output logic                    bus_enable,
    output logic                    write_enable,
    input  logic                    bus_halt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPTURE,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                  state;
    logic [23:0]             src;
    logic [23:0]             dst;
    logic [LENGTH_WIDTH-1:0] remaining;
    logic                    fill_mode;
    logic [7:0]              fill_byte;

    // Addresses wrap naturally at 24 bits (0xFFFFFF -> 0x000000).
    function automatic logic [23:0] next_addr(input logic [23:0] a);
        return a + 24'd1;
    endfunction

    // All bus outputs are registered: each transition loads the values the
    // next state presents, so a halted access keeps its outputs untouched.
    // data_out doubles as the byte register for copies.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            src          <= '0;
            dst          <= '0;
            remaining    <= '0;
            fill_mode    <= 1'b0;
            fill_byte    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            address      <= '0;
            data_out     <= '0;
            bus_enable   <= 1'b0;
            write_enable <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        src       <= src_address;
                        dst       <= dst_address;
                        remaining <= length;
                        fill_mode <= mode;
                        fill_byte <= fill_value;
                        if (length == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else if (mode) begin
                            state        <= S_WRITE;
                            busy         <= 1'b1;
                            address      <= dst_address;
                            data_out     <= fill_value;
                            bus_enable   <= 1'b1;
                            write_enable <= 1'b1;
                        end else begin
                            state      <= S_READ;
                            busy       <= 1'b1;
                            address    <= src_address;
                            bus_enable <= 1'b1;
                        end
                    end
                end

                S_READ: begin
                    if (!bus_halt) begin
                        state <= S_CAPTURE;
                    end
                end

                // Read data is valid here regardless of bus_halt.
                S_CAPTURE: begin
                    data_out     <= data_in;
                    address      <= dst;
                    write_enable <= 1'b1;
                    state        <= S_WRITE;
                end

                S_WRITE: begin
                    if (!bus_halt) begin
                        dst       <= next_addr(dst);
                        remaining <= remaining - LENGTH_WIDTH'(1);
                        if (!fill_mode) begin
                            src <= next_addr(src);
                        end
                        if (remaining == LENGTH_WIDTH'(1)) begin
                            state        <= S_DONE;
                            done         <= 1'b1;
                            busy         <= 1'b0;
                            address      <= '0;
                            data_out     <= '0;
                            bus_enable   <= 1'b0;
                            write_enable <= 1'b0;
                        end else if (fill_mode) begin
                            address  <= next_addr(dst);
                            data_out <= fill_byte;
                        end else begin
                            state        <= S_READ;
                            address      <= next_addr(src);
                            data_out     <= '0;
                            write_enable <= 1'b0;
                        end
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state        <= S_IDLE;
                    busy         <= 1'b0;
                    address      <= '0;
                    data_out     <= '0;
                    bus_enable   <= 1'b0;
                    write_enable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_dma.sv
// Testbench for bus_dma: directed transfers, expected bus writes and done
// pulses queued by the stimulus and checked by an independent monitor.
module tb_bus_dma;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        mode;
    logic [23:0] src_address;
    logic [23:0] dst_address;
    logic [15:0] length;
    logic [7:0]  fill_value;
    logic        busy;
    logic        done;
    logic [23:0] address;
    logic [7:0]  data_out;
    logic [7:0]  data_in;
    logic        bus_enable;
    logic        write_enable;
    logic        bus_halt;

    bus_dma #(.LENGTH_WIDTH(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .mode         (mode),
        .src_address  (src_address),
        .dst_address  (dst_address),
        .length       (length),
        .fill_value   (fill_value),
        .busy         (busy),
        .done         (done),
        .address      (address),
        .data_out     (data_out),
        .data_in      (data_in),
        .bus_enable   (bus_enable),
        .write_enable (write_enable),
        .bus_halt     (bus_halt)
    );

    always #5 clk = ~clk;

    // Memory model: byte at any address reads as 0xA0 + low address byte.
    assign data_in = 8'hA0 + address[7:0];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [23:0] a;
        logic [7:0]  d;
        int          c;
    } wr_t;

    wr_t wq[$];
    int  dq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every accepted write and every done pulse must match the queue.
    wr_t e;
    int  dc;
    always @(negedge clk) begin
        if (reset) begin
            if (write_enable && !bus_enable) begin
                checks++;
                errors++;
                $display("FAIL we_without_be at cycle %0d", cyc);
            end
            if (bus_enable && write_enable && !bus_halt) begin
                if (wq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h cycle %0d", address, data_out, cyc);
                end else begin
                    e = wq.pop_front();
                    chk("wr_addr", 32'(address), 32'(e.a));
                    chk("wr_data", 32'(data_out), 32'(e.d));
                    chk("wr_cycle", 32'(cyc), 32'(e.c));
                end
            end
            if (done) begin
                if (dq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done at cycle %0d", cyc);
                end else begin
                    dc = dq.pop_front();
                    chk("done_cycle", 32'(cyc), 32'(dc));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Returns sc = cycle in which start was presented.
    task automatic kick(input logic m, input logic [23:0] s, input logic [23:0] d,
                        input logic [15:0] len, input logic [7:0] f, output int sc);
        mode        = m;
        src_address = s;
        dst_address = d;
        length      = len;
        fill_value  = f;
        start       = 1'b1;
        step();
        sc    = cyc - 1;
        start = 1'b0;
    endtask

    task automatic drained(input string name);
        chk({name, "_writes_left"}, 32'(wq.size()), 32'd0);
        chk({name, "_done_left"}, 32'(dq.size()), 32'd0);
        wq.delete();
        dq.delete();
    endtask

    initial begin
        int sc;
        reset       = 1'b0;
        start       = 1'b0;
        mode        = 1'b0;
        src_address = '0;
        dst_address = '0;
        length      = '0;
        fill_value  = '0;
        bus_halt    = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_be", 32'(bus_enable), 32'd0);
        chk("rst_we", 32'(write_enable), 32'd0);
        chk("rst_addr", 32'(address), 32'd0);
        chk("rst_dout", 32'(data_out), 32'd0);
        reset = 1'b1;
        step();

        // Copy 4 bytes, no stalls
        kick(1'b0, 24'h010000, 24'h000100, 16'd4, 8'h00, sc);
        for (int k = 0; k < 4; k++)
            wq.push_back('{24'h000100 + 24'(k), 8'hA0 + 8'(k), sc + 3 + 3 * k});
        dq.push_back(sc + 13);
        for (int i = 0; i < 14; i++) begin
            chk("copy_busy", 32'(busy), 32'((cyc - sc >= 1) && (cyc - sc <= 12)));
            step();
        end
        drained("copy");

        // Halt during read
        kick(1'b0, 24'h010000, 24'h000110, 16'd1, 8'h00, sc);
        wq.push_back('{24'h000110, 8'hA0, sc + 8});
        dq.push_back(sc + 9);
        bus_halt = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hr_addr", 32'(address), 32'h010000);
            chk("hr_be", 32'(bus_enable), 32'd1);
            chk("hr_we", 32'(write_enable), 32'd0);
        end
        bus_halt = 1'b0;
        for (int i = 0; i < 6; i++) step();
        drained("halt_read");

        // Halt during write
        kick(1'b0, 24'h010005, 24'h000200, 16'd1, 8'h00, sc);
        wq.push_back('{24'h000200, 8'hA5, sc + 6});
        dq.push_back(sc + 7);
        step();
        step();
        chk("hw_we_entry", 32'(write_enable), 32'd1);
        bus_halt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hw_we", 32'(write_enable), 32'd1);
            chk("hw_addr", 32'(address), 32'h000200);
            chk("hw_dout", 32'(data_out), 32'h0000A5);
        end
        bus_halt = 1'b0;
        for (int i = 0; i < 4; i++) step();
        drained("halt_write");

        // Fill with address wrap
        kick(1'b1, 24'h000000, 24'hFFFFFE, 16'd3, 8'h55, sc);
        wq.push_back('{24'hFFFFFE, 8'h55, sc + 1});
        wq.push_back('{24'hFFFFFF, 8'h55, sc + 2});
        wq.push_back('{24'h000000, 8'h55, sc + 3});
        dq.push_back(sc + 4);
        for (int i = 0; i < 5; i++) step();
        drained("fill");

        // Zero length
        kick(1'b0, 24'h010000, 24'h000100, 16'd0, 8'h00, sc);
        dq.push_back(sc + 1);
        chk("zero_be", 32'(bus_enable), 32'd0);
        chk("zero_busy", 32'(busy), 32'd0);
        step();
        chk("zero_be_after", 32'(bus_enable), 32'd0);
        step();
        drained("zero");

        // Start while busy is ignored
        kick(1'b0, 24'h010010, 24'h000300, 16'd2, 8'h00, sc);
        wq.push_back('{24'h000300, 8'hB0, sc + 3});
        wq.push_back('{24'h000301, 8'hB1, sc + 6});
        dq.push_back(sc + 7);
        step();
        step();
        mode        = 1'b1;
        dst_address = 24'h000400;
        src_address = 24'h010040;
        length      = 16'd1;
        fill_value  = 8'h77;
        start       = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 6; i++) step();
        drained("busy_start");

        // Reset mid-write
        kick(1'b0, 24'h010020, 24'h000500, 16'd2, 8'h00, sc);
        step();
        step();
        chk("mid_we_before", 32'(write_enable), 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_done", 32'(done), 32'd0);
        chk("mid_be", 32'(bus_enable), 32'd0);
        chk("mid_we", 32'(write_enable), 32'd0);
        chk("mid_addr", 32'(address), 32'd0);
        chk("mid_dout", 32'(data_out), 32'd0);
        step();
        step();
        chk("mid_done_held", 32'(done), 32'd0);
        reset = 1'b1;
        step();
        chk("mid_idle_be", 32'(bus_enable), 32'd0);
        kick(1'b1, 24'h000000, 24'h000600, 16'd2, 8'hC3, sc);
        wq.push_back('{24'h000600, 8'hC3, sc + 1});
        wq.push_back('{24'h000601, 8'hC3, sc + 2});
        dq.push_back(sc + 3);
        for (int i = 0; i < 4; i++) step();
        drained("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
